a2d_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the single SPI A2D front end (strt_cnv / chnnl / cnv_cmplt / A2D_res). It is shared by the motion controller (IR sensors), the battery monitor and a spare requester.
- The A2D returns each conversion one transaction late. The block therefore runs two back-to-back conversions per request and returns the second result: conversion 1 selects the channel, conversion 2 retrieves its result.
- It sits between the requesting control blocks and the A2D interface block.

---
 rtl/a2d_arbiter_if.sv | 22 ++
 rtl/a2d_arbiter.sv | 163 ++++++++++++++++
 tb/tb_a2d_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/a2d_arbiter_if.sv
// A2D front-end link: conversion start/channel out, completion/result back.
// The arbiter is the master; the SPI A2D interface block is the slave.
interface a2d_arbiter_if;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] A2D_res;

  modport master (
    output strt_cnv,
    output chnnl,
    input  cnv_cmplt,
    input  A2D_res
  );

  modport slave (
    input  strt_cnv,
    input  chnnl,
    output cnv_cmplt,
    output A2D_res
  );
endinterface

// File: rtl/a2d_arbiter.sv
// Round-robin A2D sequencer: two conversions per grant, the second
// returns the result of the first (the A2D answers one transaction late).
module a2d_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int SETTLE  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   req_chnnl,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     err,
  output logic [11:0]            res,
  output logic                   busy,
  a2d_arbiter_if.master          a2d
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNV1,
    S_SETTLE,
    S_CNV2,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [2:0]        chnnl_q, chnnl_d;
  logic [11:0]       res_q, res_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [SW-1:0]     stl_q, stl_d;
  logic              strt_q, strt_d;
  logic [NUM_REQ-1:0] err_q, err_d;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IW-1:0]        pos;
  logic [IW:0]          sum;
  logic [IW-1:0]        win;
  logic [2:0]           win_ch;
  logic [IW-1:0]        nxt;
  logic [NUM_REQ-1:0]   own_oh;
  logic                 abort;

  // Rotate so the pointer sits at bit 0, pick the lowest set bit.
  always_comb begin
    req_dbl = {req, req} >> ptr_q;
    req_rot = req_dbl[NUM_REQ-1:0];
    pos = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) pos = IW'(i);
    end
    sum = {1'b0, ptr_q} + {1'b0, pos};
    if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
    win = sum[IW-1:0];
    win_ch = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IW'(i)) win_ch = req_chnnl[3*i +: 3];
    end
  end

  assign nxt = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign own_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    chnnl_d = chnnl_q;
    res_d   = res_q;
    tmo_d   = tmo_q;
    stl_d   = stl_q;
    strt_d  = 1'b0;
    err_d   = '0;
    abort   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d = win;
          chnnl_d = win_ch;
          tmo_d   = TW'(TIMEOUT);
          strt_d  = 1'b1;
          state_d = S_CNV1;
        end
      end
      S_CNV1: begin
        tmo_d = tmo_q - 1'b1;
        if (a2d.cnv_cmplt) begin
          stl_d   = SW'(SETTLE);
          state_d = S_SETTLE;
        end else if (tmo_q == TW'(1)) begin
          abort = 1'b1;
        end
      end
      S_SETTLE: begin
        stl_d = stl_q - 1'b1;
        if (stl_q <= SW'(1)) begin
          tmo_d   = TW'(TIMEOUT);
          strt_d  = 1'b1;
          state_d = S_CNV2;
        end
      end
      S_CNV2: begin
        tmo_d = tmo_q - 1'b1;
        if (a2d.cnv_cmplt) begin
          res_d   = a2d.A2D_res;
          state_d = S_DONE;
        end else if (tmo_q == TW'(1)) begin
          abort = 1'b1;
        end
      end
      S_DONE: begin
        ptr_d   = nxt;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // cnv_cmplt already took priority above, so abort is a true timeout.
    if (abort) begin
      err_d   = own_oh;
      ptr_d   = nxt;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      chnnl_q <= '0;
      res_q   <= '0;
      tmo_q   <= '0;
      stl_q   <= '0;
      strt_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      chnnl_q <= chnnl_d;
      res_q   <= res_d;
      tmo_q   <= tmo_d;
      stl_q   <= stl_d;
      strt_q  <= strt_d;
      err_q   <= err_d;
    end
  end

  assign a2d.strt_cnv = strt_q;
  assign a2d.chnnl    = chnnl_q;
  assign done = (state_q == S_DONE) ? own_oh : '0;
  assign err  = err_q;
  assign res  = res_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_a2d_arbiter.sv
// Directed bench for a2d_arbiter with a one-late A2D model.
// Model result = 12'hA58 ^ channel of the previous conversion.
module tb_a2d_arbiter;
  localparam int NR = 3;
  localparam int ST = 32;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [3*NR-1:0] req_chnnl = '0;
  logic [NR-1:0]   done, err;
  logic [11:0]     res;
  logic            busy;

  a2d_arbiter_if a2d();

  logic        mdl_cmplt = 1'b0;
  logic        spur_cmplt = 1'b0;
  logic [11:0] mdl_res = '0;
  assign a2d.cnv_cmplt = mdl_cmplt | spur_cmplt;
  assign a2d.A2D_res   = mdl_res;

  a2d_arbiter #(.NUM_REQ(NR), .SETTLE(ST), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_chnnl(req_chnnl),
    .done(done), .err(err), .res(res), .busy(busy), .a2d(a2d)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int       m_t = 40;
  bit       m_en = 1'b1;
  bit       m_busy = 1'b0;
  int       m_cnt = 0;
  logic [2:0] m_ch = '0;
  logic [2:0] m_prev = '0;

  always @(negedge clk) begin
    mdl_cmplt = 1'b0;
    if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        mdl_cmplt = 1'b1;
        mdl_res = 12'hA58 ^ {9'd0, m_prev};
        m_prev = m_ch;
        m_busy = 1'b0;
      end
    end
    if (a2d.strt_cnv && m_en && !m_busy) begin
      m_busy = 1'b1;
      m_cnt = m_t;
      m_ch = a2d.chnnl;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_tests++;
    if ({a2d.strt_cnv, a2d.chnnl, res, done, err, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: strt=%b ch=%h res=%h done=%b err=%b busy=%b required all 0",
               a2d.strt_cnv, a2d.chnnl, res, done, err, busy);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b0 || a2d.strt_cnv !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b strt=%b required 0 0", busy, a2d.strt_cnv);
    end
  endtask

  task automatic test_single();
    int s1 = -1, s2 = -1, c1 = -1, dn = -1, ns = 0;
    logic [2:0] ch1 = '0, ch2 = '0;
    logic [NR-1:0] dv = '0;
    logic [11:0] rv = '0;
    m_t = 40;
    m_en = 1'b1;
    req_chnnl = {3'd0, 3'd0, 3'd4};
    req = 3'b001;
    for (int n = 1; n <= 300 && dn < 0; n++) begin
      tick();
      if (a2d.strt_cnv) begin
        ns++;
        if (s1 < 0) begin s1 = n; ch1 = a2d.chnnl; end
        else begin s2 = n; ch2 = a2d.chnnl; end
      end
      if (a2d.cnv_cmplt && c1 < 0) c1 = n;
      if (done != '0) begin dn = n; dv = done; rv = res; req = '0; end
    end
    n_tests++;
    if (ns != 2) begin n_fail++; $display("FAIL single_strt_count: got %0d required 2", ns); end
    n_tests++;
    if (s1 != 1) begin n_fail++; $display("FAIL single_strt_latency: got %0d required 1", s1); end
    n_tests++;
    if (ch1 !== 3'd4 || ch2 !== 3'd4) begin
      n_fail++; $display("FAIL single_chnnl: got %0d,%0d required 4,4", ch1, ch2);
    end
    n_tests++;
    if (s2 - c1 != 33) begin
      n_fail++; $display("FAIL single_settle_gap: got %0d required 33", s2 - c1);
    end
    n_tests++;
    if (dn != 115) begin n_fail++; $display("FAIL single_done_cycle: got %0d required 115", dn); end
    n_tests++;
    if (dv !== 3'b001) begin n_fail++; $display("FAIL single_done_bit: got %b required 001", dv); end
    n_tests++;
    if (rv !== 12'hA5C) begin n_fail++; $display("FAIL single_res: got %h required a5c", rv); end
    tick();
    n_tests++;
    if (done !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_after_done: done=%b busy=%b required 000 0", done, busy);
    end
  endtask

  task automatic test_rr_all();
    logic [NR-1:0] exp_d [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [11:0]   exp_r [6] = '{12'hA59, 12'hA58, 12'hA5F, 12'hA59, 12'hA58, 12'hA5F};
    int k = 0;
    apply_reset();
    m_t = 5;
    req_chnnl = {3'd7, 3'd0, 3'd1};
    req = 3'b111;
    for (int n = 1; n <= 600 && k < 6; n++) begin
      tick();
      if (done != '0) begin
        n_tests++;
        if (done !== exp_d[k] || res !== exp_r[k]) begin
          n_fail++;
          $display("FAIL rr_all_%0d: done=%b res=%h required %b %h", k, done, res, exp_d[k], exp_r[k]);
        end
        k++;
        if (k == 6) req = '0;
      end
    end
    n_tests++;
    if (k != 6) begin n_fail++; $display("FAIL rr_all_count: got %0d required 6", k); end
  endtask

  task automatic test_rr_ptr2();
    logic [NR-1:0] exp_d [3] = '{3'b001, 3'b010, 3'b100};
    logic [11:0]   exp_r [3] = '{12'hA5A, 12'hA5B, 12'hA5E};
    int k = 0;
    bit raised = 1'b0;
    bit pre = 1'b0;
    m_t = 5;
    req_chnnl = {3'd6, 3'd3, 3'd2};
    req = 3'b010;
    for (int n = 1; n <= 200 && !pre; n++) begin
      tick();
      if (done != '0) begin
        pre = 1'b1;
        n_tests++;
        if (done !== 3'b010 || res !== 12'hA5B) begin
          n_fail++; $display("FAIL ptr2_pre: done=%b res=%h required 010 a5b", done, res);
        end
        req = '0;
      end
    end
    tick();
    req = 3'b011;
    for (int n = 1; n <= 600 && k < 3; n++) begin
      tick();
      if (a2d.cnv_cmplt && !raised) begin raised = 1'b1; req[2] = 1'b1; end
      if (done != '0) begin
        n_tests++;
        if (done !== exp_d[k] || res !== exp_r[k]) begin
          n_fail++;
          $display("FAIL ptr2_order_%0d: done=%b res=%h required %b %h", k, done, res, exp_d[k], exp_r[k]);
        end
        req = req & ~done;
        k++;
      end
    end
    n_tests++;
    if (k != 3) begin n_fail++; $display("FAIL ptr2_count: got %0d required 3", k); end
  endtask

  task automatic test_timeout();
    int ns = 0, s2 = -1, s3 = -1, c1 = -1, e = -1, dn = -1;
    logic [2:0] ch3 = '0;
    logic [NR-1:0] ev = '0, dv = '0;
    logic [11:0] er = '0, dr = '0;
    logic eb = 1'b1;
    m_t = 5;
    m_en = 1'b1;
    req_chnnl = {3'd0, 3'd3, 3'd1};
    req = 3'b011;
    for (int n = 1; n <= 400 && dn < 0; n++) begin
      tick();
      if (a2d.strt_cnv) begin
        ns++;
        if (ns == 2) s2 = n;
        if (ns == 3) begin s3 = n; ch3 = a2d.chnnl; end
      end
      if (a2d.cnv_cmplt && c1 < 0) begin c1 = n; m_en = 1'b0; end
      if (err != '0 && e < 0) begin
        e = n; ev = err; er = res; eb = busy;
        req[0] = 1'b0;
        m_en = 1'b1;
      end
      if (done != '0) begin dn = n; dv = done; dr = res; req = '0; end
    end
    n_tests++;
    if (e - s2 != 64) begin n_fail++; $display("FAIL tmo_delay: got %0d required 64", e - s2); end
    n_tests++;
    if (ev !== 3'b001) begin n_fail++; $display("FAIL tmo_err_bit: got %b required 001", ev); end
    n_tests++;
    if (er !== 12'hA5E) begin n_fail++; $display("FAIL tmo_res_kept: got %h required a5e", er); end
    n_tests++;
    if (eb !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: busy=%b required 0", eb); end
    n_tests++;
    if (s3 != e + 1 || ch3 !== 3'd3) begin
      n_fail++; $display("FAIL tmo_next_grant: at %0d ch %0d required %0d ch 3", s3, ch3, e + 1);
    end
    n_tests++;
    if (dv !== 3'b010 || dr !== 12'hA5B) begin
      n_fail++; $display("FAIL tmo_next_done: done=%b res=%h required 010 a5b", dv, dr);
    end
  endtask

  task automatic test_spurious();
    bit moved = 1'b0;
    req = '0;
    tick();
    spur_cmplt = 1'b1;
    tick();
    spur_cmplt = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if (busy || a2d.strt_cnv || done != '0 || err != '0) moved = 1'b1;
      tick();
    end
    n_tests++;
    if (moved) begin n_fail++; $display("FAIL spurious_idle: got activity required none"); end
  endtask

  task automatic test_timeout_edge();
    int dn = -1, e = -1;
    bit saw_err = 1'b0, saw_done = 1'b0;
    logic [NR-1:0] dv = '0, ev = '0;
    m_t = 63;
    req = 3'b001;
    for (int n = 1; n <= 300 && dn < 0; n++) begin
      tick();
      if (err != '0) saw_err = 1'b1;
      if (done != '0) begin dn = n; dv = done; req = '0; end
    end
    n_tests++;
    if (saw_err || dv !== 3'b001 || dn != 161) begin
      n_fail++;
      $display("FAIL edge_cmplt_wins: err=%b done=%b at %0d required 0 001 161", saw_err, dv, dn);
    end
    tick();
    m_t = 64;
    req = 3'b001;
    for (int n = 1; n <= 300 && e < 0; n++) begin
      tick();
      if (done != '0) saw_done = 1'b1;
      if (err != '0) begin e = n; ev = err; req = '0; end
    end
    n_tests++;
    if (saw_done || ev !== 3'b001 || e != 65) begin
      n_fail++;
      $display("FAIL edge_one_late: done=%b err=%b at %0d required 0 001 65", saw_done, ev, e);
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    int c1 = -1, k = 0;
    logic [2:0] ch1 = '0;
    bit first = 1'b1;
    logic [NR-1:0] exp_d [2] = '{3'b001, 3'b010};
    m_t = 5;
    req_chnnl = {3'd0, 3'd3, 3'd5};
    req = 3'b001;
    for (int n = 1; n <= 60 && c1 < 0; n++) begin
      tick();
      if (a2d.cnv_cmplt) c1 = n;
    end
    repeat (5) tick();
    n_tests++;
    if (busy !== 1'b1 || a2d.chnnl !== 3'd5) begin
      n_fail++; $display("FAIL rstmid_settle: busy=%b ch=%0d required 1 5", busy, a2d.chnnl);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({a2d.strt_cnv, a2d.chnnl, res, done, err, busy} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: strt=%b ch=%h res=%h done=%b err=%b busy=%b required all 0",
               a2d.strt_cnv, a2d.chnnl, res, done, err, busy);
    end
    req = '0;
    tick();
    rst_n = 1'b1;
    tick();
    req = 3'b011;
    for (int n = 1; n <= 300 && k < 2; n++) begin
      tick();
      if (a2d.strt_cnv && first) begin first = 1'b0; ch1 = a2d.chnnl; end
      if (done != '0) begin
        n_tests++;
        if (done !== exp_d[k]) begin
          n_fail++; $display("FAIL rstmid_order_%0d: got %b required %b", k, done, exp_d[k]);
        end
        req = req & ~done;
        k++;
      end
    end
    n_tests++;
    if (ch1 !== 3'd5 || k != 2) begin
      n_fail++; $display("FAIL rstmid_restart: ch=%0d dones=%0d required 5 2", ch1, k);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_all();
    test_rr_ptr2();
    test_timeout();
    test_spurious();
    test_timeout_edge();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
